// File: rtl/poke_pkg.sv
// poke_pkg -- shared types for the wild-encounter controller.
//   enc_state_t : encounter FSM state (IDLE, ROLL, OFFER, BATTLE)
//   poke_id_t   : 3-bit species index
//   NUM_SPECIES : number of valid species; raw indices at or above it fold to 0
package poke_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROLL   = 2'd1,
    ST_OFFER  = 2'd2,
    ST_BATTLE = 2'd3
  } enc_state_t;

  typedef logic [2:0] poke_id_t;

  localparam int NUM_SPECIES = 5;

  // The random source can produce 0-7 but only 0-4 are real species.
  function automatic poke_id_t map_species(input logic [2:0] raw);
    return (int'(raw) < NUM_SPECIES) ? poke_id_t'(raw) : poke_id_t'(0);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8 -- 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Shifts left; the new LSB is the XOR of bits 7,5,4,3.
//   Clk     : clock, rising edge
//   Reset_n : synchronous active-low reset, loads seed
//   seed    : reset value (must be non-zero)
//   adv     : advance one step this cycle
//   value   : current register value
module lfsr8 (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] seed,
  input  logic       adv,
  output logic [7:0] value
);

  logic [7:0] r_value;
  logic       w_fb;

  assign w_fb  = r_value[7] ^ r_value[5] ^ r_value[4] ^ r_value[3];
  assign value = r_value;

  always_ff @(posedge Clk) begin
    if (!Reset_n)  r_value <= seed;
    else if (adv)  r_value <= {r_value[6:0], w_fb};
  end

endmodule

// File: rtl/encounter_ctrl.sv
// encounter_ctrl -- decides when walking through tall grass triggers a wild
// encounter, offers it to the battle engine and tracks the battle.
//   Clk, Reset_n      : clock, synchronous active-low reset
//   step, in_grass    : tile-move pulse, player-on-grass flag
//   poke_num          : species from the random source; rng_en enables that source
//   enc_valid/ready   : handshake to the battle engine, wild_id held while valid
//   battle_done       : battle engine ends the battle
//   battle_active     : high while in BATTLE
//   enc_count         : accepted encounters, wraps
// Build option: define ENCOUNTER_REPEL_EN to add repel_start and a 100-step
// repel counter that blocks encounters while non-zero.
module encounter_ctrl
  import poke_pkg::*;
#(
  parameter int         MIN_STEPS = 4,
  parameter logic [7:0] RATE      = 8'd40,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       step,
  input  logic       in_grass,
  input  logic [2:0] poke_num,
`ifdef ENCOUNTER_REPEL_EN
  input  logic       repel_start,
`endif
  output logic       rng_en,
  output logic       enc_valid,
  input  logic       enc_ready,
  output poke_id_t   wild_id,
  input  logic       battle_done,
  output logic       battle_active,
  output logic [7:0] enc_count
);

  enc_state_t r_state, w_state_nxt;
  logic [7:0] r_step_cnt;
  logic [7:0] r_enc_cnt;
  poke_id_t   r_wild_id;
  logic [7:0] w_lfsr;
  logic [8:0] w_cnt_inc;
  logic       w_qual, w_roll_ok, w_xfer, w_blk;

  // Only steps taken in grass while idle count; everything else is ignored.
  assign w_qual    = step & in_grass & (r_state == ST_IDLE);
  assign w_cnt_inc = {1'b0, r_step_cnt} + 9'd1;
  // Roll uses the LFSR value before this step's advance.
  assign w_roll_ok = (int'(w_cnt_inc) >= MIN_STEPS) && (w_lfsr < RATE);
  assign w_xfer    = (r_state == ST_OFFER) & enc_ready;

`ifdef ENCOUNTER_REPEL_EN
  logic [6:0] r_repel;

  always_ff @(posedge Clk) begin
    if (!Reset_n)                         r_repel <= '0;
    else if (repel_start)                 r_repel <= 7'd100;
    else if (w_qual && (r_repel != '0))   r_repel <= r_repel - 7'd1;
  end

  // Blocking decision uses the count before this step's decrement.
  assign w_blk = (r_repel != '0);
`else
  assign w_blk = 1'b0;
`endif

  lfsr8 u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .seed    (LFSR_SEED),
    .adv     (w_qual),
    .value   (w_lfsr)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_qual && w_roll_ok && !w_blk) w_state_nxt = ST_ROLL;
      ST_ROLL:   w_state_nxt = ST_OFFER;
      ST_OFFER:  if (enc_ready)   w_state_nxt = ST_BATTLE;
      ST_BATTLE: if (battle_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_step_cnt <= '0;
      r_enc_cnt  <= '0;
      r_wild_id  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer)                           r_step_cnt <= '0;
      else if (w_qual && r_step_cnt != 8'hFF) r_step_cnt <= r_step_cnt + 8'd1;
      if (w_xfer)                r_enc_cnt <= r_enc_cnt + 8'd1;
      if (r_state == ST_ROLL)    r_wild_id <= map_species(poke_num);
    end
  end

  // Species source frozen once an encounter is committed, and during reset.
  assign rng_en        = Reset_n & ((r_state == ST_IDLE) | (r_state == ST_ROLL));
  assign enc_valid     = (r_state == ST_OFFER);
  assign battle_active = (r_state == ST_BATTLE);
  assign wild_id       = r_wild_id;
  assign enc_count     = r_enc_cnt;

endmodule

// File: tb/tb_encounter_ctrl.sv
// tb_encounter_ctrl -- self-checking bench for encounter_ctrl.
// Three instances share inputs: u_hi (RATE=255), u_zero (RATE=0), u_def (defaults).
module tb_encounter_ctrl;
  import poke_pkg::*;

  logic Clk = 1'b0, Reset_n = 1'b0, step = 1'b0, in_grass = 1'b0;
  logic enc_ready = 1'b0, battle_done = 1'b0;
  logic [2:0] poke_num = 3'd0;
`ifdef ENCOUNTER_REPEL_EN
  logic repel_start = 1'b0;
`endif

  logic h_rng_en, h_enc_valid, h_battle_active; poke_id_t h_wild_id; logic [7:0] h_enc_count;
  logic z_rng_en, z_enc_valid, z_battle_active; poke_id_t z_wild_id; logic [7:0] z_enc_count;
  logic d_rng_en, d_enc_valid, d_battle_active; poke_id_t d_wild_id; logic [7:0] d_enc_count;

  int checks = 0, errors = 0;

  // Reference model: encounter bookkeeping as plain numbers.
  logic [7:0] m_lfsr;
  int m_cnt, m_enc, m_repel;

  always #5 Clk = ~Clk;

  encounter_ctrl #(.MIN_STEPS(4), .RATE(8'd255), .LFSR_SEED(8'hA5)) u_hi (
    .Clk(Clk), .Reset_n(Reset_n), .step(step), .in_grass(in_grass), .poke_num(poke_num),
`ifdef ENCOUNTER_REPEL_EN
    .repel_start(repel_start),
`endif
    .rng_en(h_rng_en), .enc_valid(h_enc_valid), .enc_ready(enc_ready), .wild_id(h_wild_id),
    .battle_done(battle_done), .battle_active(h_battle_active), .enc_count(h_enc_count));

  encounter_ctrl #(.MIN_STEPS(4), .RATE(8'd0), .LFSR_SEED(8'hA5)) u_zero (
    .Clk(Clk), .Reset_n(Reset_n), .step(step), .in_grass(in_grass), .poke_num(poke_num),
`ifdef ENCOUNTER_REPEL_EN
    .repel_start(repel_start),
`endif
    .rng_en(z_rng_en), .enc_valid(z_enc_valid), .enc_ready(enc_ready), .wild_id(z_wild_id),
    .battle_done(battle_done), .battle_active(z_battle_active), .enc_count(z_enc_count));

  encounter_ctrl u_def (
    .Clk(Clk), .Reset_n(Reset_n), .step(step), .in_grass(in_grass), .poke_num(poke_num),
`ifdef ENCOUNTER_REPEL_EN
    .repel_start(repel_start),
`endif
    .rng_en(d_rng_en), .enc_valid(d_enc_valid), .enc_ready(enc_ready), .wild_id(d_wild_id),
    .battle_done(battle_done), .battle_active(d_battle_active), .enc_count(d_enc_count));

  // x^8+x^6+x^5+x^4+1 in shift-left form: new LSB = parity of the tapped bits.
  function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic logic [2:0] exp_species(input logic [2:0] n);
    return (n > 3'd4) ? 3'd0 : n;
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset;
    m_lfsr = 8'hA5; m_cnt = 0; m_enc = 0; m_repel = 0;
  endtask

  // One idle-state step as seen by the model; returns whether it starts an encounter.
  task automatic model_step(input bit g, input int rate, output bit fire);
    fire = 1'b0;
    if (g) begin
      fire = (m_cnt + 1 >= 4) && (int'(m_lfsr) < rate) && (m_repel == 0);
      m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_lfsr = lfsr_adv(m_lfsr);
      if (m_repel > 0) m_repel = m_repel - 1;
    end
  endtask

  task automatic apply_reset;
    Reset_n = 1'b0; step = 1'b0; in_grass = 1'b0; enc_ready = 1'b0; battle_done = 1'b0;
`ifdef ENCOUNTER_REPEL_EN
    repel_start = 1'b0;
`endif
    tick; tick;
    Reset_n = 1'b1;
    model_reset;
  endtask

  // Grass steps on u_hi until the model predicts an encounter, then hold pn during ROLL.
  task automatic offer_with(input logic [2:0] pn, output bit ok);
    bit fire;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step = 1'b1; in_grass = 1'b1;
      model_step(1'b1, 255, fire);
      tick;
      step = 1'b0; in_grass = 1'b0;
      if (fire) begin
        poke_num = pn;
        tick;
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; step = 1'b1; in_grass = 1'b1;
    tick;
    checks++; if (h_rng_en !== 1'b0) begin errors++; $display("FAIL reset_rng_en got %b want 0", h_rng_en); end
    checks++; if (h_enc_valid !== 1'b0) begin errors++; $display("FAIL reset_enc_valid got %b want 0", h_enc_valid); end
    checks++; if (h_battle_active !== 1'b0) begin errors++; $display("FAIL reset_battle_active got %b want 0", h_battle_active); end
    checks++; if (h_enc_count !== 8'd0) begin errors++; $display("FAIL reset_enc_count got %0d want 0", h_enc_count); end
    checks++; if (h_wild_id !== 3'd0) begin errors++; $display("FAIL reset_wild_id got %0d want 0", h_wild_id); end
    tick;
    Reset_n = 1'b1; step = 1'b0; in_grass = 1'b0;
    model_reset;
    #1;
    checks++; if (h_rng_en !== 1'b1) begin errors++; $display("FAIL idle_rng_en got %b want 1", h_rng_en); end
    checks++; if (u_hi.r_step_cnt !== 8'd0) begin errors++; $display("FAIL reset_step_cnt got %0d want 0", u_hi.r_step_cnt); end
  endtask

  // Steps 1-3 never roll; step 4 gives enc_valid two cycles later.
  task automatic test_min_steps;
    bit fire;
    apply_reset;
    poke_num = 3'd3;
    for (int k = 1; k <= 4; k++) begin
      step = 1'b1; in_grass = 1'b1;
      model_step(1'b1, 255, fire);
      tick;
      step = 1'b0; in_grass = 1'b0;
      checks++; if (h_enc_valid !== 1'b0) begin errors++; $display("FAIL minstep_n1 step %0d got %b want 0", k, h_enc_valid); end
      tick;
      checks++; if (h_enc_valid !== fire) begin errors++; $display("FAIL minstep_n2 step %0d got %b want %b", k, h_enc_valid, fire); end
    end
    checks++; if (h_wild_id !== 3'd3) begin errors++; $display("FAIL species_3 got %0d want 3", h_wild_id); end
    checks++; if (h_rng_en !== 1'b0) begin errors++; $display("FAIL offer_rng_en got %b want 0", h_rng_en); end
  endtask

  // Continues from OFFER: ready held low, noisy inputs, then accept and finish.
  task automatic test_offer_hold;
    for (int i = 0; i < 10; i++) begin
      enc_ready = 1'b0; poke_num = 3'($urandom); step = 1'($urandom); in_grass = 1'($urandom);
      battle_done = 1'($urandom);
      tick;
      checks++; if (h_enc_valid !== 1'b1 || h_wild_id !== 3'd3) begin errors++;
        $display("FAIL offer_hold cyc %0d got valid=%b id=%0d want valid=1 id=3", i, h_enc_valid, h_wild_id); end
    end
    step = 1'b0; in_grass = 1'b0; battle_done = 1'b0;
    enc_ready = 1'b1;
    tick;
    enc_ready = 1'b0;
    m_enc = 1; m_cnt = 0;
    checks++; if (h_battle_active !== 1'b1) begin errors++; $display("FAIL accept_battle got %b want 1", h_battle_active); end
    checks++; if (h_enc_count !== 8'(m_enc)) begin errors++; $display("FAIL accept_count got %0d want %0d", h_enc_count, m_enc); end
    checks++; if (h_enc_valid !== 1'b0) begin errors++; $display("FAIL accept_valid got %b want 0", h_enc_valid); end
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; in_grass = 1'b1; tick;
    end
    step = 1'b0; in_grass = 1'b0;
    checks++; if (h_battle_active !== 1'b1 || h_rng_en !== 1'b0) begin errors++;
      $display("FAIL battle_hold got act=%b rng=%b want act=1 rng=0", h_battle_active, h_rng_en); end
    battle_done = 1'b1; tick; battle_done = 1'b0;
    checks++; if (h_battle_active !== 1'b0 || h_rng_en !== 1'b1) begin errors++;
      $display("FAIL battle_end got act=%b rng=%b want act=0 rng=1", h_battle_active, h_rng_en); end
    checks++; if (u_hi.r_step_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL battle_step_cnt got %0d want %0d", u_hi.r_step_cnt, m_cnt); end
  endtask

  task automatic test_species;
    logic [2:0] tbl [6];
    bit ok;
    tbl = '{3'd6, 3'd3, 3'd5, 3'd7, 3'd4, 3'd0};
    for (int t = 0; t < 6; t++) begin
      offer_with(tbl[t], ok);
      checks++; if (!ok || h_enc_valid !== 1'b1 || h_wild_id !== exp_species(tbl[t])) begin errors++;
        $display("FAIL species raw %0d got ok=%b valid=%b id=%0d want valid=1 id=%0d", tbl[t], ok, h_enc_valid, h_wild_id, exp_species(tbl[t])); end
      enc_ready = 1'b1; tick; enc_ready = 1'b0;
      m_enc = (m_enc + 1) % 256; m_cnt = 0;
      checks++; if (h_enc_count !== 8'(m_enc)) begin errors++; $display("FAIL species_count got %0d want %0d", h_enc_count, m_enc); end
      battle_done = 1'b1; tick; battle_done = 1'b0;
    end
  endtask

  task automatic test_reset_in_battle;
    bit ok;
    apply_reset;
    for (int e = 0; e < 3; e++) begin
      offer_with(3'($urandom), ok);
      checks++; if (!ok || h_enc_valid !== 1'b1) begin errors++; $display("FAIL rib_offer %0d got ok=%b valid=%b want 1", e, ok, h_enc_valid); end
      enc_ready = 1'b1; tick; enc_ready = 1'b0;
      m_enc++; m_cnt = 0;
      if (e < 2) begin battle_done = 1'b1; tick; battle_done = 1'b0; end
    end
    checks++; if (h_battle_active !== 1'b1 || h_enc_count !== 8'd3) begin errors++;
      $display("FAIL rib_pre got act=%b cnt=%0d want act=1 cnt=3", h_battle_active, h_enc_count); end
    Reset_n = 1'b0;
    tick;
    checks++; if (h_battle_active !== 1'b0 || h_enc_count !== 8'd0 || h_enc_valid !== 1'b0 || h_rng_en !== 1'b0) begin errors++;
      $display("FAIL rib_post got act=%b cnt=%0d valid=%b rng=%b want 0 0 0 0", h_battle_active, h_enc_count, h_enc_valid, h_rng_en); end
    Reset_n = 1'b1;
    model_reset;
  endtask

  task automatic test_rate_zero;
    bit seen;
    apply_reset;
    for (int i = 0; i < 10; i++) begin step = 1'b1; in_grass = 1'b0; tick; end
    step = 1'b0;
    checks++; if (u_zero.r_step_cnt !== 8'd0) begin errors++; $display("FAIL nograss_cnt got %0d want 0", u_zero.r_step_cnt); end
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step = 1'b1; in_grass = 1'b1; tick;
      if (z_enc_valid !== 1'b0 || z_rng_en !== 1'b1) seen = 1'b1;
    end
    step = 1'b0; in_grass = 1'b0;
    tick;
    checks++; if (seen || z_enc_valid !== 1'b0) begin errors++; $display("FAIL rate0_idle got left_idle=%b want 0", seen); end
    checks++; if (u_zero.r_step_cnt !== 8'd255) begin errors++; $display("FAIL rate0_sat got %0d want 255", u_zero.r_step_cnt); end
  endtask

  // Random walk on u_def (RATE=40) against the model.
  task automatic test_random;
    bit fire, s, g;
    int cyc, n_enc, w;
    logic [2:0] pn;
    apply_reset;
    cyc = 0; n_enc = 0;
    while (n_enc < 6 && cyc < 4000) begin
      s = 1'($urandom); g = ($urandom_range(0, 3) != 0);
      step = s; in_grass = g; poke_num = 3'($urandom);
      enc_ready = 1'($urandom); battle_done = 1'($urandom);
      model_step(s & g, 40, fire);
      tick; cyc++;
      step = 1'b0; in_grass = 1'b0; enc_ready = 1'b0; battle_done = 1'b0;
      checks++; if (d_enc_valid !== 1'b0 || d_battle_active !== 1'b0 || d_enc_count !== 8'(m_enc)) begin errors++;
        $display("FAIL rnd_idle cyc %0d got valid=%b act=%b cnt=%0d want 0 0 %0d", cyc, d_enc_valid, d_battle_active, d_enc_count, m_enc); end
      if (fire) begin
        pn = 3'($urandom); poke_num = pn; step = 1'($urandom); in_grass = 1'b1;
        tick; cyc++;
        checks++; if (d_enc_valid !== 1'b1 || d_wild_id !== exp_species(pn) || d_rng_en !== 1'b0) begin errors++;
          $display("FAIL rnd_offer got valid=%b id=%0d rng=%b want 1 %0d 0", d_enc_valid, d_wild_id, d_rng_en, exp_species(pn)); end
        w = $urandom_range(0, 4);
        for (int i = 0; i < w; i++) begin
          poke_num = 3'($urandom); step = 1'($urandom); in_grass = 1'($urandom); battle_done = 1'($urandom);
          tick; cyc++;
          checks++; if (d_enc_valid !== 1'b1 || d_wild_id !== exp_species(pn)) begin errors++;
            $display("FAIL rnd_hold got valid=%b id=%0d want 1 %0d", d_enc_valid, d_wild_id, exp_species(pn)); end
        end
        step = 1'b0; battle_done = 1'b0; enc_ready = 1'b1;
        tick; cyc++;
        enc_ready = 1'b0;
        m_enc = (m_enc + 1) % 256; m_cnt = 0; n_enc++;
        checks++; if (d_battle_active !== 1'b1 || d_enc_count !== 8'(m_enc)) begin errors++;
          $display("FAIL rnd_accept got act=%b cnt=%0d want 1 %0d", d_battle_active, d_enc_count, m_enc); end
        w = $urandom_range(0, 4);
        for (int i = 0; i < w; i++) begin
          step = 1'($urandom); in_grass = 1'($urandom); enc_ready = 1'($urandom);
          tick; cyc++;
        end
        step = 1'b0; in_grass = 1'b0; enc_ready = 1'b0;
        checks++; if (d_battle_active !== 1'b1) begin errors++; $display("FAIL rnd_battle got %b want 1", d_battle_active); end
        battle_done = 1'b1; tick; cyc++; battle_done = 1'b0;
        checks++; if (d_battle_active !== 1'b0 || d_rng_en !== 1'b1) begin errors++;
          $display("FAIL rnd_done got act=%b rng=%b want 0 1", d_battle_active, d_rng_en); end
      end
    end
    checks++; if (n_enc < 6) begin errors++; $display("FAIL rnd_budget got %0d encounters want 6", n_enc); end
  endtask

`ifdef ENCOUNTER_REPEL_EN
  task automatic test_repel;
    bit fire, seen;
    apply_reset;
    repel_start = 1'b1; tick; repel_start = 1'b0;
    m_repel = 100;
    seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step = 1'b1; in_grass = 1'b1;
      model_step(1'b1, 255, fire);
      tick;
      if (fire || h_enc_valid !== 1'b0) seen = 1'b1;
    end
    step = 1'b0; in_grass = 1'b0;
    tick;
    checks++; if (seen || h_enc_valid !== 1'b0) begin errors++; $display("FAIL repel_block got enc=%b want 0", seen | h_enc_valid); end
    step = 1'b1; in_grass = 1'b1;
    model_step(1'b1, 255, fire);
    tick;
    step = 1'b0; in_grass = 1'b0;
    tick;
    checks++; if (h_enc_valid !== fire) begin errors++; $display("FAIL repel_step101 got %b want %b", h_enc_valid, fire); end
  endtask
`endif

  initial begin
    test_reset;
    test_min_steps;
    test_offer_hold;
    test_species;
    test_reset_in_battle;
    test_rate_zero;
    test_random;
`ifdef ENCOUNTER_REPEL_EN
    test_repel;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/encounter_ctrl.md
ENCOUNTER_CTRL -- requirements
Module: encounter_ctrl

Interface
REQ-001 SHALL have parameter MIN_STEPS, default 4: grass steps required since last battle before any encounter roll.
REQ-002 SHALL have parameter RATE, default 8'd40: encounter fires when the 8-bit rate LFSR value < RATE.
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, non-zero: reset value of the rate LFSR.
REQ-004 SHALL have port Clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port Reset_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port step  in  1  one-cycle pulse per completed player tile move.
REQ-007 SHALL have port in_grass  in  1  player tile is tall grass.
REQ-008 SHALL have port poke_num  in  3  species index from random_num.
REQ-009 SHALL have port rng_en  out  1  enable driven to random_num.
REQ-010 SHALL have ports enc_valid  out  1, enc_ready  in  1: valid/ready handshake to the battle engine.
REQ-011 SHALL have port wild_id  out  3  latched species, stable while enc_valid=1.
REQ-012 SHALL have port battle_done  in  1  pulse from the battle engine ending the battle.
REQ-013 SHALL have ports battle_active  out  1 and enc_count  out  8 (encounters accepted, wraps 255->0).

Function
REQ-014 SHALL implement FSM IDLE, ROLL, OFFER, BATTLE; state type in shared package.
REQ-015 SHALL keep step_cnt (8-bit, saturating at 255), incremented on step&in_grass in IDLE only.
REQ-016 SHALL advance the rate LFSR (x^8+x^6+x^5+x^4+1) once per qualifying step in IDLE only.
REQ-017 SHALL move IDLE->ROLL when step&in_grass, step_cnt+1 >= MIN_STEPS and current LFSR value < RATE; otherwise stay IDLE.
REQ-018 SHALL drive rng_en=1 in IDLE and ROLL, 0 in OFFER and BATTLE (species frozen during battle).
REQ-019 SHALL in ROLL (exactly one cycle) latch wild_id from poke_num, mapping values 5-7 to 0, then enter OFFER.
REQ-020 SHALL assert enc_valid throughout OFFER with wild_id constant; transfer occurs on the cycle enc_valid&enc_ready.
REQ-021 SHALL on transfer enter BATTLE, increment enc_count, clear step_cnt to 0.
REQ-022 SHALL hold battle_active=1 in BATTLE only; battle_done in BATTLE returns to IDLE next cycle.
REQ-023 SHALL ignore step in ROLL/OFFER/BATTLE and battle_done outside BATTLE.
REQ-024 SHALL keep OFFER unaffected by in_grass dropping; the offer is never withdrawn.
REQ-025 SHALL have latency: qualifying step at cycle N -> ROLL N+1 -> enc_valid=1 at N+2.

Reset
REQ-026 SHALL on Reset_n=0 at a clock edge: state IDLE, step_cnt 0, LFSR LFSR_SEED, wild_id 0, enc_count 0, enc_valid 0, battle_active 0.
REQ-027 SHALL with Reset_n=0 drive rng_en=0; reset mid-OFFER/BATTLE aborts with no enc_count change.

Configuration
REQ-028 SHALL, with macro ENCOUNTER_REPEL_EN defined, add input repel_start (pulse) and 7-bit repel counter loaded with 100; counter decrements per qualifying step; REQ-017 transition suppressed while counter non-zero; step_cnt and LFSR still advance.
REQ-029 SHALL, without ENCOUNTER_REPEL_EN, have no repel_start port and no repel logic.

Structure
REQ-030 SHALL place enc_state_t, poke_id_t (3-bit) and NUM_SPECIES=5 in package poke_pkg.
REQ-031 SHALL implement the rate LFSR as sub-module lfsr8 (Clk, Reset_n, seed, adv, value).

Verification
REQ-032 SHALL cover: RATE=8'd255, MIN_STEPS=4, 4 grass steps -> no roll on steps 1-3, enc_valid at 2 cycles after step 4.
REQ-033 SHALL cover: poke_num=3'd6 during ROLL -> wild_id=0; poke_num=3'd3 -> wild_id=3.
REQ-034 SHALL cover: enc_ready low 10 cycles in OFFER, poke_num toggling -> wild_id and enc_valid stable; ready high -> battle_active next cycle, enc_count=1.
REQ-035 SHALL cover: RATE=0, 300 grass steps -> never leaves IDLE, step_cnt=255; steps with in_grass=0 -> no count.
REQ-036 SHALL cover: Reset_n=0 in BATTLE with enc_count=3 -> IDLE, enc_count=0, battle_active=0 after one edge.
REQ-037 SHALL cover (ENCOUNTER_REPEL_EN): RATE=255, repel_start then 100 grass steps -> no encounter; step 101 -> enc_valid.
